// File: rtl/multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl
//   Moore controller for the 64-bit multicycle MIPS datapath. Executes one
//   instruction at a time: FETCH -> DECODE -> per-class execute, memory and
//   writeback states, then back to FETCH. Every datapath strobe is decoded
//   from the current state. The only exceptions are these:
//     - pcen also depends on the ALU zero flag.
//     - A few fields (ltype, dtype, the immediate ALU setup, and the R-type
//       ALU op) depend on op/funct. The instruction register holds op/funct
//       stable for the whole instruction.
//
// Ports
//   clk         in   1   rising-edge clock
//   reset       in   1   asynchronous, active-low; forces FETCH
//   op          in   6   instr[31:26]
//   funct       in   6   instr[5:0]
//   zero        in   1   ALU zero flag (same-cycle)
//   pcen        out  1   PC load enable
//   irwrite     out  1   instruction register load
//   regwrite    out  1   register file write
//   memwrite    out  1   memory write strobe
//   dtype       out  1   1 = doubleword access (ld/sd)
//   iord        out  1   memory address: 0 = pc, 1 = aluout
//   memtoreg    out  1   writeback source: 0 = aluout, 1 = data register
//   regdst      out  1   destination: 0 = rt, 1 = rd
//   alusrca     out  1   ALU A: 0 = pc, 1 = register A
//   alusrcb     out  3   ALU B select
//   pcsrc       out  2   PC source select
//   alucontrol  out  4   ALU operation
//   ltype       out  2   load extension type
//   state       out  SW  current state (debug)
// -----------------------------------------------------------------------------
module multicycle_ctrl #(
  parameter int SW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [5:0]    op,
  input  logic [5:0]    funct,
  input  logic          zero,
  output logic          pcen,
  output logic          irwrite,
  output logic          regwrite,
  output logic          memwrite,
  output logic          dtype,
  output logic          iord,
  output logic          memtoreg,
  output logic          regdst,
  output logic          alusrca,
  output logic [2:0]    alusrcb,
  output logic [1:0]    pcsrc,
  output logic [3:0]    alucontrol,
  output logic [1:0]    ltype,
  output logic [SW-1:0] state
);

  // State encodings
  localparam logic [SW-1:0] S_FETCH  = SW'(0);
  localparam logic [SW-1:0] S_DECODE = SW'(1);
  localparam logic [SW-1:0] S_MEMADR = SW'(2);
  localparam logic [SW-1:0] S_MEMRD  = SW'(3);
  localparam logic [SW-1:0] S_MEMWB  = SW'(4);
  localparam logic [SW-1:0] S_MEMWR  = SW'(5);
  localparam logic [SW-1:0] S_REXEC  = SW'(6);
  localparam logic [SW-1:0] S_ALUWB  = SW'(7);
  localparam logic [SW-1:0] S_BEQ    = SW'(8);
  localparam logic [SW-1:0] S_BNE    = SW'(9);
  localparam logic [SW-1:0] S_IEXEC  = SW'(10);
  localparam logic [SW-1:0] S_IWB    = SW'(11);
  localparam logic [SW-1:0] S_JUMP   = SW'(12);

  // Opcodes
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_LB   = 6'b100000;
  localparam logic [5:0] OP_LBU  = 6'b100100;
  localparam logic [5:0] OP_LD   = 6'b110111;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_SD   = 6'b111111;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_J    = 6'b000010;

  // R-type funct codes
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // ALU operations
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  logic [SW-1:0] state_q, state_d;
  logic          is_load, is_store, is_imm;
  logic          pcwrite, branch, branchne;
  logic [3:0]    r_aluop;

  assign is_load  = (op == OP_LW) || (op == OP_LB) || (op == OP_LBU) || (op == OP_LD);
  assign is_store = (op == OP_SW) || (op == OP_SD);
  assign is_imm   = (op == OP_ADDI) || (op == OP_SLTI) || (op == OP_ANDI) || (op == OP_ORI);

  // R-type ALU op; unknown funct codes fall back to ADD
  always_comb begin
    case (funct)
      FN_SUB:  r_aluop = ALU_SUB;
      FN_AND:  r_aluop = ALU_AND;
      FN_OR:   r_aluop = ALU_OR;
      FN_SLT:  r_aluop = ALU_SLT;
      FN_ADD:  r_aluop = ALU_ADD;
      default: r_aluop = ALU_ADD;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        if (is_load || is_store)  state_d = S_MEMADR;
        else if (op == OP_R)      state_d = S_REXEC;
        else if (op == OP_BEQ)    state_d = S_BEQ;
        else if (op == OP_BNE)    state_d = S_BNE;
        else if (is_imm)          state_d = S_IEXEC;
        else if (op == OP_J)      state_d = S_JUMP;
        else                      state_d = S_FETCH;  // illegal op: 2-cycle NOP
      end
      S_MEMADR: begin
        if (is_load)       state_d = S_MEMRD;
        else if (is_store) state_d = S_MEMWR;
        else               state_d = S_FETCH;
      end
      S_MEMRD:  state_d = S_MEMWB;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  state_d = S_FETCH;
      S_REXEC:  state_d = S_ALUWB;
      S_ALUWB:  state_d = S_FETCH;
      S_BEQ:    state_d = S_FETCH;
      S_BNE:    state_d = S_FETCH;
      S_IEXEC:  state_d = S_IWB;
      S_IWB:    state_d = S_FETCH;
      S_JUMP:   state_d = S_FETCH;
      default:  state_d = S_FETCH;  // unused encodings recover to FETCH
    endcase
  end

  // Output decode: all selects and strobes default to 0
  always_comb begin
    pcwrite    = 1'b0;
    branch     = 1'b0;
    branchne   = 1'b0;
    irwrite    = 1'b0;
    regwrite   = 1'b0;
    memwrite   = 1'b0;
    dtype      = 1'b0;
    iord       = 1'b0;
    memtoreg   = 1'b0;
    regdst     = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 3'b000;
    pcsrc      = 2'b00;
    alucontrol = ALU_AND;
    ltype      = 2'b00;
    case (state_q)
      S_FETCH: begin
        irwrite    = 1'b1;
        alusrcb    = 3'b001;
        alucontrol = ALU_ADD;
        pcwrite    = 1'b1;
      end
      S_DECODE: begin
        // Branch target precomputed into aluout
        alusrcb    = 3'b011;
        alucontrol = ALU_ADD;
      end
      S_MEMADR: begin
        alusrca    = 1'b1;
        alusrcb    = 3'b010;
        alucontrol = ALU_ADD;
      end
      S_MEMRD: begin
        // ltype must be valid here; the data register captures at the end of this cycle
        iord  = 1'b1;
        dtype = (op == OP_LD);
        if (op == OP_LB)       ltype = 2'b10;
        else if (op == OP_LBU) ltype = 2'b01;
        else                   ltype = 2'b00;
      end
      S_MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
        dtype    = (op == OP_LD);
      end
      S_MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
        dtype    = (op == OP_SD);
      end
      S_REXEC: begin
        alusrca    = 1'b1;
        alucontrol = r_aluop;
      end
      S_ALUWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
      end
      S_BEQ: begin
        alusrca    = 1'b1;
        alucontrol = ALU_SUB;
        pcsrc      = 2'b01;
        branch     = 1'b1;
      end
      S_BNE: begin
        alusrca    = 1'b1;
        alucontrol = ALU_SUB;
        pcsrc      = 2'b01;
        branchne   = 1'b1;
      end
      S_IEXEC: begin
        alusrca = 1'b1;
        case (op)
          OP_SLTI: begin alusrcb = 3'b010; alucontrol = ALU_SLT; end
          OP_ANDI: begin alusrcb = 3'b100; alucontrol = ALU_AND; end
          OP_ORI:  begin alusrcb = 3'b100; alucontrol = ALU_OR;  end
          default: begin alusrcb = 3'b010; alucontrol = ALU_ADD; end
        endcase
      end
      S_IWB: begin
        regwrite = 1'b1;
      end
      S_JUMP: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
      end
      default: ;
    endcase
  end

  assign pcen  = pcwrite | (branch & zero) | (branchne & ~zero);
  assign state = state_q;

endmodule
